boid_frame_sequencer: RTL and testbench

- Per-frame controller for the boid register memory and its pairwise-interaction and integrate datapaths.
- On a frame trigger it sweeps every boid twice:
  - Accumulate phase: for each boid i, iterates over every other boid j, then writes vx_acc/vy_acc back.
  - Update phase: for each boid i, runs position/velocity integration, then writes x/y/vx/vy back.
- Drives the memory's which_boid/wb_en controls and the datapaths' req/ack handshakes. Sits between the frame-timing logic and the memory wrapper.

---
 rtl/boid_frame_sequencer.sv | 216 +++++++++++++++++++++
 tb/tb_boid_frame_sequencer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/boid_frame_sequencer.sv
// Per-frame sweep controller for the boid memory: accumulate pass over all pairs, then integrate pass.
// Optional ack watchdog enabled by defining BOID_SEQ_TIMEOUT_EN.
module boid_frame_sequencer #(
  parameter int unsigned num_boids = 2,
  parameter int unsigned IW        = $clog2(num_boids) + 1,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          frame_start,
  output logic          busy,
  output logic          frame_done,
  output logic [IW-1:0] which_boid,
  output logic [6:0]    wb_en,
  output logic          self_latch,
  output logic [IW-1:0] self_idx,
  output logic          pair_req,
  input  logic          pair_ack,
  output logic          upd_req,
  input  logic          upd_ack,
  output logic          err
);

  // One extra bit so j can step past the last index without wrapping.
  localparam int unsigned CW = IW + 1;
  localparam logic [CW-1:0] LAST = CW'(num_boids - 1);

  localparam logic [6:0] WB_ACC = 7'b1100001;
  localparam logic [6:0] WB_UPD = 7'b0011111;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ACC_LATCH = 3'd1;
  localparam logic [2:0] S_ACC_PAIR  = 3'd2;
  localparam logic [2:0] S_ACC_WB    = 3'd3;
  localparam logic [2:0] S_UPD_REQ   = 3'd4;
  localparam logic [2:0] S_UPD_WB    = 3'd5;
  localparam logic [2:0] S_DONE      = 3'd6;

  if (num_boids < 1) begin : g_bad_num_boids
    $error("boid_frame_sequencer: num_boids must be at least 1");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("boid_frame_sequencer: TIMEOUT must be at least 1");
  end

  logic [2:0]    state_q, state_n;
  logic [CW-1:0] i_q, i_n;
  logic [CW-1:0] j_q, j_n;
  logic [CW-1:0] j_adv;
  logic          tmo_hit;
  logic          pair_go;
  logic          upd_go;

  logic          busy_n;
  logic          frame_done_n;
  logic [IW-1:0] which_boid_n;
  logic [6:0]    wb_en_n;
  logic          self_latch_n;
  logic [IW-1:0] self_idx_n;
  logic          pair_req_n;
  logic          upd_req_n;

`ifdef BOID_SEQ_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] tmo_cnt;
  logic          req_active;
  logic          ack_now;

  assign req_active = (state_q == S_ACC_PAIR) || (state_q == S_UPD_REQ);
  assign ack_now    = ((state_q == S_ACC_PAIR) && pair_ack) ||
                      ((state_q == S_UPD_REQ) && upd_ack);
  assign tmo_hit    = req_active && !ack_now && (tmo_cnt == TW'(TIMEOUT - 1));

  // Watchdog: counts cycles a request waits, forces progress at the limit.
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt <= '0;
      err     <= 1'b0;
    end else begin
      if (!req_active || ack_now || tmo_hit) begin
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end
      err <= err | tmo_hit;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign err     = 1'b0;
`endif

  assign pair_go = pair_ack | tmo_hit;
  assign upd_go  = upd_ack | tmo_hit;

  // Next-state logic; outputs are decoded from the next state so they register in step with it.
  always_comb begin
    state_n = state_q;
    i_n     = i_q;
    j_n     = j_q;
    j_adv   = j_q + CW'(1);
    if (j_adv == i_q) begin
      j_adv = j_q + CW'(2);
    end

    case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          i_n     = '0;
          state_n = S_ACC_LATCH;
        end
      end
      S_ACC_LATCH: begin
        if (num_boids == 1) begin
          state_n = S_ACC_WB;
        end else begin
          j_n     = (i_q == '0) ? CW'(1) : '0;
          state_n = S_ACC_PAIR;
        end
      end
      S_ACC_PAIR: begin
        if (pair_go) begin
          if (j_adv > LAST) begin
            state_n = S_ACC_WB;
          end else begin
            j_n = j_adv;
          end
        end
      end
      S_ACC_WB: begin
        if (i_q == LAST) begin
          i_n     = '0;
          state_n = S_UPD_REQ;
        end else begin
          i_n     = i_q + CW'(1);
          state_n = S_ACC_LATCH;
        end
      end
      S_UPD_REQ: begin
        if (upd_go) begin
          state_n = S_UPD_WB;
        end
      end
      S_UPD_WB: begin
        if (i_q == LAST) begin
          state_n = S_DONE;
        end else begin
          i_n     = i_q + CW'(1);
          state_n = S_UPD_REQ;
        end
      end
      S_DONE: begin
        i_n     = '0;
        state_n = S_IDLE;
      end
      default: begin
        i_n     = '0;
        j_n     = '0;
        state_n = S_IDLE;
      end
    endcase

    busy_n       = (state_n != S_IDLE);
    frame_done_n = (state_n == S_DONE);
    self_latch_n = (state_n == S_ACC_LATCH);
    pair_req_n   = (state_n == S_ACC_PAIR);
    upd_req_n    = (state_n == S_UPD_REQ);
    self_idx_n   = (state_n == S_IDLE) ? '0 : IW'(i_n);
    which_boid_n = '0;
    wb_en_n      = '0;
    case (state_n)
      S_ACC_LATCH: which_boid_n = IW'(i_n);
      S_ACC_PAIR:  which_boid_n = IW'(j_n);
      S_ACC_WB: begin
        which_boid_n = IW'(i_n);
        wb_en_n      = WB_ACC;
      end
      S_UPD_REQ:   which_boid_n = IW'(i_n);
      S_UPD_WB: begin
        which_boid_n = IW'(i_n);
        wb_en_n      = WB_UPD;
      end
      default: which_boid_n = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      i_q        <= '0;
      j_q        <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      which_boid <= '0;
      wb_en      <= '0;
      self_latch <= 1'b0;
      self_idx   <= '0;
      pair_req   <= 1'b0;
      upd_req    <= 1'b0;
    end else begin
      state_q    <= state_n;
      i_q        <= i_n;
      j_q        <= j_n;
      busy       <= busy_n;
      frame_done <= frame_done_n;
      which_boid <= which_boid_n;
      wb_en      <= wb_en_n;
      self_latch <= self_latch_n;
      self_idx   <= self_idx_n;
      pair_req   <= pair_req_n;
      upd_req    <= upd_req_n;
    end
  end

endmodule

// File: tb/tb_boid_frame_sequencer.sv
// Directed bench for boid_frame_sequencer: N=2 timing/write pattern, restart/reset handling, N=3 with slow pair_ack.
module tb_boid_frame_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       fs2, pa2, ua2;
  logic       busy2, done2, sl2, preq2, ureq2, err2;
  logic [1:0] which2, self2;
  logic [6:0] wb2;

  logic       fs3, pa3, ua3;
  logic       busy3, done3, sl3, preq3, ureq3, err3;
  logic [2:0] which3, self3;
  logic [6:0] wb3;

  boid_frame_sequencer #(.num_boids(2)) dut2 (
    .clk(clk), .reset(reset), .frame_start(fs2), .busy(busy2), .frame_done(done2),
    .which_boid(which2), .wb_en(wb2), .self_latch(sl2), .self_idx(self2),
    .pair_req(preq2), .pair_ack(pa2), .upd_req(ureq2), .upd_ack(ua2), .err(err2)
  );

  boid_frame_sequencer #(.num_boids(3)) dut3 (
    .clk(clk), .reset(reset), .frame_start(fs3), .busy(busy3), .frame_done(done3),
    .which_boid(which3), .wb_en(wb3), .self_latch(sl3), .self_idx(self3),
    .pair_req(preq3), .pair_ack(pa3), .upd_req(ureq3), .upd_ack(ua3), .err(err3)
  );

  int passed = 0;
  int failed = 0;
  int total  = 0;

  int exp_which [10] = '{0, 1, 0, 1, 0, 1, 0, 0, 1, 1};
  int exp_self  [11] = '{0, 0, 0, 1, 1, 1, 0, 0, 1, 1, 1};

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] exp_wb(input int c);
    case (c)
      3, 6:    return 7'b1100001;
      8, 10:   return 7'b0011111;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic logic [2:0] exp_hs(input int c);
    case (c)
      1, 4:    return 3'b100;
      2, 5:    return 3'b010;
      7, 9:    return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  int n, writes, done_cnt, bad_self, pairs, run, bad_stable;
  logic [2:0] held_which, held_self;

  initial begin
    reset = 1'b1;
    fs2 = 1'b0; pa2 = 1'b1; ua2 = 1'b1;
    fs3 = 1'b0; pa3 = 1'b0; ua3 = 1'b1;
    repeat (2) step();
    chk("reset_outputs", 32'({busy2, done2, which2, wb2, sl2, self2, preq2, ureq2, err2}), 32'd0);
    reset = 1'b0;
    step();
    chk("idle_busy", 32'(busy2), 32'd0);

    // Frame with both acks tied high: cycle-by-cycle pattern.
    bad_self = 0;
    fs2 = 1'b1;
    step();
    fs2 = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      chk($sformatf("busy_c%0d", c), 32'(busy2), 32'(c <= 11));
      chk($sformatf("done_c%0d", c), 32'(done2), 32'(c == 11));
      chk($sformatf("wb_en_c%0d", c), 32'(wb2), 32'(exp_wb(c)));
      chk($sformatf("latch_pair_upd_c%0d", c), 32'({sl2, preq2, ureq2}), 32'(exp_hs(c)));
      if (c <= 10) chk($sformatf("which_c%0d", c), 32'(which2), 32'(exp_which[c-1]));
      if (c <= 11) chk($sformatf("self_idx_c%0d", c), 32'(self2), 32'(exp_self[c-1]));
      if (preq2 && which2 == self2) bad_self++;
      step();
    end
    chk("pair_self_overlap", 32'(bad_self), 32'd0);

    // Re-trigger while busy and in the DONE cycle: both dropped.
    done_cnt = 0;
    fs2 = 1'b1;
    step();
    fs2 = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      done_cnt += int'(done2);
      if (c == 11) chk("retrig_done_c11", 32'(done2), 32'd1);
      if (c == 12) chk("retrig_idle_c12", 32'(busy2), 32'd0);
      fs2 = (c == 5 || c == 11);
      step();
      fs2 = 1'b0;
    end
    chk("retrig_done_count", 32'(done_cnt), 32'd1);
    chk("retrig_idle_end", 32'(busy2), 32'd0);

    // Reset in the second UPD_REQ cycle, then a clean frame.
    fs2 = 1'b1;
    step();
    fs2 = 1'b0;
    repeat (8) step();
    chk("mid_upd_req", 32'({ureq2, which2}), 32'({1'b1, 2'd1}));
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_reset_outputs", 32'({busy2, done2, which2, wb2, sl2, self2, preq2, ureq2, err2}), 32'd0);
    step();
    chk("post_reset_idle", 32'({busy2, wb2}), 32'd0);
    fs2 = 1'b1;
    step();
    fs2 = 1'b0;
    chk("restart_first", 32'({busy2, sl2, which2, self2}), 32'({1'b1, 1'b1, 2'd0, 2'd0}));
    n = 0;
    writes = 0;
    while (busy2 && n < 50) begin
      n++;
      if (wb2 != 7'd0) writes++;
      step();
    end
    chk("restart_busy_cycles", 32'(n), 32'd11);
    chk("restart_writes", 32'(writes), 32'd4);

    // N=3 with pair_ack given on the fourth cycle of each request.
    fs3 = 1'b1;
    step();
    fs3 = 1'b0;
    n = 0; pairs = 0; run = 0; bad_stable = 0;
    held_which = '0; held_self = '0;
    while (busy3 && n < 200) begin
      n++;
      if (preq3) begin
        run++;
        if (run == 1) begin
          held_which = which3;
          held_self  = self3;
          if (which3 == self3) bad_stable++;
        end else if (which3 != held_which || self3 != held_self) begin
          bad_stable++;
        end
        pa3 = (run == 4);
        if (pa3) begin
          pairs++;
          run = 0;
        end
      end else begin
        if (run != 0) bad_stable++;
        pa3 = 1'b0;
        run = 0;
      end
      step();
    end
    pa3 = 1'b0;
    chk("n3_busy_cycles", 32'(n), 32'd37);
    chk("n3_pairs", 32'(pairs), 32'd6);
    chk("n3_pair_hold_stable", 32'(bad_stable), 32'd0);
    chk("n3_err", 32'(err3), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
